uart_prog_loader: RTL

- Boot-time instruction loader upstream of the pipeline's instruction fetch stage.
- Receives a program image over UART (8N1, LSB first), assembles little-endian 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the CPU core in reset via `cpu_hold` until the image is complete.
- Re-arms on `reload` so a new program can be downloaded without a board reset.

---
 rtl/uart_prog_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a length-prefixed program image (8N1, LSB first),
// assembles little-endian 32-bit words and writes them to instruction memory
// from word address 0, holding the CPU in reset until the image is complete.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_WIDTH   = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  frame_err,
    output logic [15:0]           word_cnt
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HDR0, HDR1, B0, B1, B2, B3, WRITE, DONE} ld_state_t;

    rx_state_t       rx_state;
    ld_state_t       state;
    logic            rx_meta;
    logic            rx_sync;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic            stop_err;
    logic [7:0]      hdr_lo;
    logic [15:0]     hdr_n;
    logic [15:0]     n_words;
    logic [23:0]     word_buf;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver FSM: mid-bit sampling, emits one-cycle byte_valid or stop_err pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else if (reload) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        clk_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt == CW'(HALF - 1)) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            stop_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Word count as it would be after the HDR1 byte is captured.
    always_comb begin
        hdr_n = {rx_byte, hdr_lo};
    end

    // Loader FSM: header capture, word assembly, memory writes and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HDR0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            word_cnt   <= '0;
            hdr_lo     <= '0;
            n_words    <= '0;
            word_buf   <= '0;
        end else if (reload) begin
            state     <= HDR0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;
            word_cnt  <= '0;
        end else begin
            imem_we <= 1'b0;
            // Once the image is complete the line is ignored, including framing errors.
            if (stop_err && state != DONE) begin
                frame_err <= 1'b1;
                state     <= HDR0;
                imem_addr <= '0;
                word_cnt  <= '0;
            end else begin
                case (state)
                    HDR0: if (byte_valid) begin
                        hdr_lo <= rx_byte;
                        state  <= HDR1;
                    end
                    HDR1: if (byte_valid) begin
                        n_words <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state    <= DONE;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else if (32'(hdr_n) > DEPTH) begin
                            frame_err <= 1'b1;
                            state     <= HDR0;
                        end else begin
                            state <= B0;
                        end
                    end
                    B0: if (byte_valid) begin
                        word_buf[7:0] <= rx_byte;
                        state         <= B1;
                    end
                    B1: if (byte_valid) begin
                        word_buf[15:8] <= rx_byte;
                        state          <= B2;
                    end
                    B2: if (byte_valid) begin
                        word_buf[23:16] <= rx_byte;
                        state           <= B3;
                    end
                    B3: if (byte_valid) begin
                        imem_wdata <= {rx_byte, word_buf};
                        imem_we    <= 1'b1;
                        state      <= WRITE;
                    end
                    WRITE: begin
                        imem_addr <= imem_addr + ADDR_WIDTH'(1);
                        word_cnt  <= word_cnt + 16'd1;
                        if (word_cnt + 16'd1 == n_words) begin
                            state    <= DONE;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= B0;
                        end
                    end
                    DONE: ;
                    default: state <= HDR0;
                endcase
            end
        end
    end

endmodule
